branch_predictor: RTL

Dynamic branch predictor for the 16-bit WISC pipeline. It sits directly upstream of the fetch PC mux and alongside the branch cache. It holds an 8-entry direct-mapped table of valid/tag/target/2-bit-counter entries. The current fetch PC is looked up combinationally to produce a taken/target prediction. When decode resolves a branch, the entry for that branch's PC is allocated or trained and a mispredict is flagged.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 8-entry direct-mapped table of valid/tag/target/2-bit counter.
// Lookup is combinational from PC_curr; decode-time resolutions allocate or train one entry per cycle.
module branch_predictor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] PC_curr,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] PC_prev,
  input  logic             was_pred_taken,
  input  logic [WIDTH-1:0] was_pred_target,
  input  logic             actual_taken,
  input  logic [WIDTH-1:0] actual_target,
  output logic             mispredict
);

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;
  localparam int TAG_W   = WIDTH - 4;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Saturating 2-bit counter step; MSB is the predicted direction.
  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_en;
  logic             wr_hit;
  logic             unused_pc_lsb;

  // Bit 0 of a PC never selects an entry (instructions are halfword aligned).
  assign unused_pc_lsb = PC_curr[0] ^ PC_prev[0];

  // ---------------------------------------------------------------- lookup
  assign rd_idx = PC_curr[IDX_W:1];
  assign rd_tag = PC_curr[WIDTH-1:4];

  always_comb begin
    pred_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken  = pred_hit && ctr_q[rd_idx][1];
    pred_target = pred_hit ? target_q[rd_idx] : '0;
  end

  // ------------------------------------------------------------ mispredict
  // A flush is needed on a wrong direction, or on a correct taken guess to the wrong place.
  assign mispredict = upd_valid &&
                      ((actual_taken != was_pred_taken) ||
                       (actual_taken && was_pred_taken && (actual_target != was_pred_target)));

  // ---------------------------------------------------------------- update
  assign wr_idx = PC_prev[IDX_W:1];
  assign wr_tag = PC_prev[WIDTH-1:4];
  assign wr_en  = upd_valid && enable;
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    if (wr_en) begin
      if (wr_hit) begin
        ctr_d[wr_idx] = ctr_train(ctr_q[wr_idx], actual_taken);
        if (actual_taken) begin
          target_d[wr_idx] = actual_target;
        end
      end else begin
        // Allocation evicts whatever aliased into this slot and starts weak.
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = actual_target;
        ctr_d[wr_idx]    = actual_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
    end
  end

endmodule
